// File: rtl/sad_accumulator.sv
// sad_accumulator
//
// Sums N per-pixel absolute differences into one block SAD per candidate
// position. It then tracks the minimum SAD over CAND consecutive candidates,
// together with the index of the candidate that produced it. The result is
// handed to the match-result logic through a done/done_ack handshake.
//
// Ports:
//   clk           system clock; all state updates on the rising edge
//   rst_n         synchronous active-low reset
//   start         begin a new search (honoured only while idle)
//   in_valid      in_diff carries a valid absolute difference this cycle
//   in_diff       unsigned 8-bit |ref - data| from the abs-diff stage
//   in_ready      block accepts in_diff this cycle (transfer = in_valid & in_ready)
//   blk_sad_valid one-cycle pulse: blk_sad holds a completed candidate SAD
//   blk_sad       SAD of the candidate just finished (held until the next one)
//   done          search complete; best_sad / best_idx are valid
//   best_sad      minimum SAD over all candidates of the search
//   best_idx      index of the minimum-SAD candidate (earliest one wins ties)
//   done_ack      consumer acknowledges the result and releases done

module sad_accumulator #(
  parameter int N    = 16,
  parameter int CAND = 4,
  parameter int SW   = 8 + $clog2(N),
  parameter int IW   = (CAND > 1) ? $clog2(CAND) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_diff,
  output logic          in_ready,
  output logic          blk_sad_valid,
  output logic [SW-1:0] blk_sad,
  output logic          done,
  output logic [SW-1:0] best_sad,
  output logic [IW-1:0] best_idx,
  input  logic          done_ack
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    COMPARE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [SW-1:0] acc;
  logic [SW-1:0] acc_sum;
  logic [SW-1:0] min_sad;
  logic [SW-1:0] blk_sad_q;
  logic [PW-1:0] pix_cnt;
  logic [IW-1:0] cand_cnt;
  logic [IW-1:0] best_idx_q;
  logic          xfer;
  logic          last_pix;
  logic          last_cand;

  assign xfer      = (state == ACCUM) && in_valid;
  assign last_pix  = (pix_cnt == PW'(N - 1));
  assign last_cand = (cand_cnt == IW'(CAND - 1));
  assign acc_sum   = acc + SW'(in_diff);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    blk_sad_valid = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (xfer && last_pix) begin
          state_nxt = COMPARE;
        end
      end
      COMPARE: begin
        blk_sad_valid = 1'b1;
        state_nxt     = last_cand ? DONE : ACCUM;
      end
      DONE: begin
        done = 1'b1;
        if (done_ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: accumulator, counters and running minimum.
  // blk_sad is captured on the final transfer of a candidate, so it already
  // equals acc during the COMPARE cycle and then simply holds its value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      pix_cnt    <= '0;
      cand_cnt   <= '0;
      min_sad    <= '0;
      best_idx_q <= '0;
      blk_sad_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc        <= '0;
            pix_cnt    <= '0;
            cand_cnt   <= '0;
            min_sad    <= '1;
            best_idx_q <= '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc     <= acc_sum;
            pix_cnt <= pix_cnt + 1'b1;
            if (last_pix) begin
              blk_sad_q <= acc_sum;
            end
          end
        end
        COMPARE: begin
          // Strict compare so that ties keep the earlier candidate index
          if (acc < min_sad) begin
            min_sad    <= acc;
            best_idx_q <= cand_cnt;
          end
          if (!last_cand) begin
            cand_cnt <= cand_cnt + 1'b1;
            acc      <= '0;
            pix_cnt  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign blk_sad  = blk_sad_q;
  assign best_sad = min_sad;
  assign best_idx = best_idx_q;

endmodule

// File: doc/sad_accumulator.md
Name: sad_accumulator

Overview:
- Downstream consumer of the 8-bit absolute-difference stage in the template-matching datapath.
- Sums N per-pixel absolute differences into one block SAD (sum of absolute differences) per candidate position.
- Compares the SADs of CAND consecutive candidates and reports the minimum SAD and the index of the candidate that produced it.
- Feeds the match-result/control logic through a done/ack handshake.

Parameters:
- N, 16, pixels per block (number of diffs summed per candidate); N >= 1.
- CAND, 4, candidate positions per search; CAND >= 2.
- SW, 8+$clog2(N), SAD width; holds 255*N without overflow.
- IW, (CAND>1 ? $clog2(CAND) : 1), candidate index width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- start  input  1  begin a new search; honoured only in IDLE.
- in_valid  input  1  in_diff carries a valid absolute difference this cycle.
- in_diff  input  8  unsigned |ref - data| from the abs-diff stage.
- in_ready  output  1  block accepts in_diff this cycle; a transfer occurs when in_valid & in_ready.
- blk_sad_valid  output  1  one-cycle pulse: blk_sad holds a completed candidate SAD.
- blk_sad  output  SW  SAD of the candidate just finished.
- done  output  1  search complete; best_sad and best_idx are valid.
- best_sad  output  SW  minimum SAD over all candidates.
- best_idx  output  IW  index (0..CAND-1) of the minimum-SAD candidate.
- done_ack  input  1  consumer acknowledges the result; releases done.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State -> IDLE.
  - in_ready, blk_sad_valid, done = 0.
  - blk_sad, best_sad, best_idx, accumulator, pixel counter, candidate counter = 0.
  - Reset mid-search aborts with no output pulse.
- States:
  - IDLE: in_ready=0. start=1 -> clear acc, pix_cnt and cand_cnt; min <= all-ones; best_idx <= 0; go to ACCUM.
  - ACCUM: in_ready=1. Each transfer: acc <= acc + in_diff (zero-extended to SW); pix_cnt++. Cycles with in_valid=0 are bubbles and change nothing. The transfer with pix_cnt==N-1 moves to COMPARE with acc holding the final sum.
  - COMPARE (exactly one cycle): in_ready=0; blk_sad_valid=1; blk_sad=acc.
    - If acc < min (strictly less): min <= acc and best_idx <= cand_cnt. Ties keep the earlier index.
    - If cand_cnt==CAND-1: go to DONE.
    - Otherwise: cand_cnt++, acc <= 0, pix_cnt <= 0, return to ACCUM.
  - DONE: done=1, in_ready=0. best_sad (= min) and best_idx are held stable. done_ack=1 -> IDLE, and done drops the next cycle.
- Latency:
  - Last diff of a candidate accepted at edge t -> blk_sad_valid high in cycle t+1.
  - For the final candidate, done rises at t+2.
- Throughput: N+1 cycles per candidate with no bubbles.
- Ignored inputs:
  - start is ignored in ACCUM, COMPARE and DONE.
  - in_valid is ignored whenever in_ready=0; no data is accepted in IDLE, COMPARE or DONE.
- Overflow: none possible, because SW holds 255*N.
- blk_sad retains its last value after the blk_sad_valid pulse.
- best_sad and best_idx retain their values after DONE until the next start.

Test Plan:
- N=16, CAND=4, candidate diffs constant at 10, 5, 20, 5 -> blk_sad pulses 160, 80, 320, 80; best_sad=80, best_idx=1 (tie keeps the earlier index); done held until done_ack.
- All in_diff=255, N=16 -> every blk_sad=4080 with no wrap; best_sad=4080, best_idx=0.
- Random in_valid gaps (~50% duty) with candidate sums 300, 120, 121, 500 -> bubbles not counted; best_sad=120, best_idx=1.
- Latency: last diff at edge t -> blk_sad_valid in cycle t+1 (exactly one cycle wide), done at t+2; in_ready=0 during COMPARE and DONE.
- rst_n=0 mid-ACCUM of candidate 2, then a fresh start with diffs 1, 2, 3, 0 -> state, counters and accumulator cleared, no stale pulse; result best_sad=0, best_idx=3.
- start pulsed during ACCUM and during DONE -> no effect; done stays high until done_ack; the next start after IDLE begins a clean search.
